// File: rtl/shift_operand_pipe.sv
// Pipelined shifter-operand unit: LSL/LSR/ASR/ROR/RRX/rotated-immediate with carry-out,
// computed at the input and carried through an elastic valid/ready register chain.
module shift_operand_pipe #(
  parameter int XLEN  = 32,
  parameter int AMT_W = 8,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_mode,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic             out_carry,
  output logic             busy
);

  typedef enum logic [2:0] {
    M_LSL   = 3'd0,
    M_LSR   = 3'd1,
    M_ASR   = 3'd2,
    M_ROR   = 3'd3,
    M_RRX   = 3'd4,
    M_IMM   = 3'd5,
    M_PASS6 = 3'd6,
    M_PASS7 = 3'd7
  } mode_e;

  function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] v, input int unsigned r);
    logic [2*XLEN-1:0] w;
    w = {v, v} >> r;
    return w[XLEN-1:0];
  endfunction

  logic [XLEN-1:0] res_data;
  logic            res_carry;
  logic [XLEN:0]   wide;
  int unsigned     n_amt;
  int unsigned     rot;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_data  = in_data;
    res_carry = in_carry;
    wide      = '0;
    rot       = 0;
    n_amt     = 32'(in_amt);
    case (mode_e'(in_mode))
      // The extra bit beside the datapath catches the last bit shifted out,
      // which gives the ARM amount>=XLEN carry rules for free.
      M_LSL: if (n_amt != 0) begin
        wide      = {1'b0, in_data} << n_amt;
        res_data  = wide[XLEN-1:0];
        res_carry = wide[XLEN];
      end
      M_LSR: if (n_amt != 0) begin
        wide      = {in_data, 1'b0} >> n_amt;
        res_data  = wide[XLEN:1];
        res_carry = wide[0];
      end
      M_ASR: if (n_amt != 0) begin
        wide      = $signed({in_data, 1'b0}) >>> n_amt;
        res_data  = wide[XLEN:1];
        res_carry = wide[0];
      end
      M_ROR: if (n_amt != 0) begin
        rot       = n_amt % XLEN;
        res_data  = rotr(in_data, rot);
        res_carry = res_data[XLEN-1];
      end
      M_RRX: begin
        res_data  = {in_carry, in_data[XLEN-1:1]};
        res_carry = in_data[0];
      end
      M_IMM: begin
        rot      = 32'({in_amt[3:0], 1'b0}) % XLEN;
        res_data = rotr(XLEN'(in_data[7:0]), rot);
        if (in_amt[3:0] != 4'd0) res_carry = res_data[XLEN-1];
      end
      default: ;
    endcase
  end

  logic [PIPE-1:0] stg_valid;
  logic [PIPE-1:0] stg_carry;
  logic [PIPE-1:0] stg_rdy;
  logic [XLEN-1:0] stg_data [PIPE];
  logic            rdy_acc;

  // Stage k may load when it, or any stage downstream of it, is empty, or the sink accepts.
  always_comb begin
    stg_rdy = '0;
    rdy_acc = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      rdy_acc    = rdy_acc | ~stg_valid[k];
      stg_rdy[k] = rdy_acc;
    end
  end

  assign in_ready  = !flush && stg_rdy[0];
  assign out_valid = stg_valid[PIPE-1];
  assign out_data  = stg_data[PIPE-1];
  assign out_carry = stg_carry[PIPE-1];
  assign busy      = |stg_valid;

  // NOTE: sequential state uses non-blocking assignments only, so stage-to-stage
  // moves all see pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      stg_carry <= '0;
      // NOTE: the data registers are reset too because out_data must read 0 in reset;
      // a plain datapath array would normally be left unreset.
      for (int k = 0; k < PIPE; k++) stg_data[k] <= '0;
    end else if (flush) begin
      stg_valid <= '0;
    end else begin
      if (stg_rdy[0]) begin
        stg_valid[0] <= in_valid;
        if (in_valid) begin
          stg_data[0]  <= res_data;
          stg_carry[0] <= res_carry;
        end
      end
      for (int k = 1; k < PIPE; k++) begin
        if (stg_rdy[k]) begin
          stg_valid[k] <= stg_valid[k-1];
          if (stg_valid[k-1]) begin
            stg_data[k]  <= stg_data[k-1];
            stg_carry[k] <= stg_carry[k-1];
          end
        end
      end
    end
  end

endmodule
